// File: rtl/ext_pkg.sv
// Shared constants for the pipelined immediate extender: mode codes and a
// legality helper used by the extension core.
package ext_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_SEXT  = 3'd0;
    localparam logic [MODE_W-1:0] MODE_ZEXT  = 3'd1;
    localparam logic [MODE_W-1:0] MODE_UPPER = 3'd2;
    localparam logic [MODE_W-1:0] MODE_SBR   = 3'd3;
    localparam logic [MODE_W-1:0] MODE_ZBR   = 3'd4;
    localparam logic [MODE_W-1:0] MODE_SBYTE = 3'd5;

    // Codes above SBYTE are reserved and reported as errors.
    function automatic logic mode_is_legal(input logic [MODE_W-1:0] mode);
        return (mode <= MODE_SBYTE);
    endfunction

endpackage

// File: rtl/ext_pipe_if.sv
// Valid/ready request and response channels of the immediate extender.
// The master side is the producer/consumer, the slave side is ext_pipe.
interface ext_pipe_if #(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32
);
    import ext_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [IMM_W-1:0]  in_imm;
    logic [MODE_W-1:0] in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_err;

    modport master (
        output in_valid, in_imm, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_imm, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_err
    );

endinterface

// File: rtl/ext_core.sv
// Combinational immediate extender: maps (imm, mode) to an OUT_W-bit operand
// plus an illegal-mode flag.
module ext_core
    import ext_pkg::*;
#(
    parameter int IMM_W    = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic [IMM_W-1:0]  imm,
    input  logic [MODE_W-1:0] mode,
    output logic [OUT_W-1:0]  data,
    output logic              err
);

    if (IMM_W < 8 || IMM_W >= OUT_W || BR_SHIFT >= OUT_W) begin : g_bad_params
        $error("ext_core: need 8 <= IMM_W < OUT_W and BR_SHIFT < OUT_W");
    end

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sbyte;

    always_comb begin
        sext  = {{(OUT_W-IMM_W){imm[IMM_W-1]}}, imm};
        zext  = {{(OUT_W-IMM_W){1'b0}}, imm};
        sbyte = {{(OUT_W-8){imm[7]}}, imm[7:0]};

        // NOTE: outputs get a default before the case so an unlisted mode cannot infer a latch.
        data = '0;
        err  = !mode_is_legal(mode);
        case (mode)
            MODE_SEXT:  data = sext;
            MODE_ZEXT:  data = zext;
            MODE_UPPER: data = zext << (OUT_W - IMM_W);
            MODE_SBR:   data = sext << BR_SHIFT;
            MODE_ZBR:   data = zext << BR_SHIFT;
            MODE_SBYTE: data = sbyte;
            default:    data = '0;
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// Pipelined immediate extender: one-cycle latency output register backed by a
// one-entry skid so full throughput survives back-pressure.
module ext_pipe
    import ext_pkg::*;
#(
    parameter int IMM_W    = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flush,
    ext_pipe_if.slave  bus
);

    logic [OUT_W-1:0] core_data;
    logic             core_err;

    ext_core #(
        .IMM_W    (IMM_W),
        .OUT_W    (OUT_W),
        .BR_SHIFT (BR_SHIFT)
    ) u_core (
        .imm  (bus.in_imm),
        .mode (bus.in_mode),
        .data (core_data),
        .err  (core_err)
    );

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q,  out_data_d;
    logic             out_err_q,   out_err_d;
    logic             skid_full_q, skid_full_d;
    logic [OUT_W-1:0] skid_data_q, skid_data_d;
    logic             skid_err_q,  skid_err_d;

    logic in_ready;
    logic accept;
    logic out_xfer;
    logic out_load;

    assign in_ready = !skid_full_q;
    assign accept   = bus.in_valid && in_ready;
    assign out_xfer = out_valid_q && bus.out_ready;
    assign out_load = !out_valid_q || out_xfer;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        skid_full_d = skid_full_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;

        if (out_load) begin
            // A full skid always wins so items leave in acceptance order.
            if (skid_full_q) begin
                out_valid_d = 1'b1;
                out_data_d  = skid_data_q;
                out_err_d   = skid_err_q;
                skid_full_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_data_d  = core_data;
                out_err_d   = core_err;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_full_d = 1'b1;
            skid_data_d = core_data;
            skid_err_d  = core_err;
        end

        // Flush drops everything, including this cycle's offer; payload is left as is.
        if (flush) begin
            out_valid_d = 1'b0;
            out_data_d  = out_data_q;
            out_err_d   = out_err_q;
            skid_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            skid_full_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            skid_full_q <= skid_full_d;
        end
    end

    // NOTE: skid payload has no reset; it is only ever read while skid_full_q is set.
    always_ff @(posedge clk) begin
        skid_data_q <= skid_data_d;
        skid_err_q  <= skid_err_d;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: mode vector table, back-pressure, flush,
// reset and a 12/64-bit parameter instance.
module tb_ext_pipe;
    import ext_pkg::*;

    logic clk;
    logic reset_n;
    logic flush;

    int tests_run;
    int tests_failed;

    ext_pipe_if #(.IMM_W(16), .OUT_W(32)) bus ();
    ext_pipe_if #(.IMM_W(12), .OUT_W(64)) bus2 ();

    ext_pipe #(.IMM_W(16), .OUT_W(32), .BR_SHIFT(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus.slave)
    );

    ext_pipe #(.IMM_W(12), .OUT_W(64), .BR_SHIFT(1)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] imm;
        logic [2:0]  mode;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [11:0] imm;
        logic [2:0]  mode;
        logic [63:0] exp_data;
        logic        exp_err;
    } vec64_t;

    vec_t   vecs[10];
    vec64_t vecs64[3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [15:0] imm, input logic [2:0] mode);
        bus.in_valid = 1'b1;
        bus.in_imm   = imm;
        bus.in_mode  = mode;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        vecs[0] = '{16'h8001, MODE_SEXT,  32'hFFFF8001, 1'b0};
        vecs[1] = '{16'h8001, MODE_ZEXT,  32'h00008001, 1'b0};
        vecs[2] = '{16'h8001, MODE_UPPER, 32'h80010000, 1'b0};
        vecs[3] = '{16'h8001, MODE_SBR,   32'hFFFE0004, 1'b0};
        vecs[4] = '{16'h8001, MODE_ZBR,   32'h00020004, 1'b0};
        vecs[5] = '{16'h0080, MODE_SBYTE, 32'hFFFFFF80, 1'b0};
        vecs[6] = '{16'h1234, 3'd6,       32'h00000000, 1'b1};
        vecs[7] = '{16'h1234, MODE_SEXT,  32'h00001234, 1'b0};
        vecs[8] = '{16'hFFFF, 3'd7,       32'h00000000, 1'b1};
        vecs[9] = '{16'hFF7F, MODE_SBYTE, 32'h0000007F, 1'b0};

        vecs64[0] = '{12'h800, MODE_SBR,   64'hFFFFFFFFFFFFF000, 1'b0};
        vecs64[1] = '{12'h800, MODE_UPPER, 64'h8000000000000000, 1'b0};
        vecs64[2] = '{12'h080, MODE_SBYTE, 64'hFFFFFFFFFFFFFF80, 1'b0};

        reset_n        = 1'b0;
        flush          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_imm     = '0;
        bus.in_mode    = '0;
        bus.out_ready  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_imm    = '0;
        bus2.in_mode   = '0;
        bus2.out_ready = 1'b0;
        step();
        step();
        reset_n = 1'b1;

        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_out_data",  64'(bus.out_data),  64'd0);
        check("reset_out_err",   64'(bus.out_err),   64'd0);
        check("reset_in_ready",  64'(bus.in_ready),  64'd1);

        // Mode table, streamed back to back with the consumer always ready.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            offer(vecs[i].imm, vecs[i].mode);
            check($sformatf("tbl%0d_in_ready", i), 64'(bus.in_ready), 64'd1);
            step();
            check($sformatf("tbl%0d_out_valid", i), 64'(bus.out_valid), 64'd1);
            check($sformatf("tbl%0d_out_data", i),  64'(bus.out_data),  64'(vecs[i].exp_data));
            check($sformatf("tbl%0d_out_err", i),   64'(bus.out_err),   64'(vecs[i].exp_err));
        end
        bus.in_valid = 1'b0;
        step();
        check("tbl_drain_valid", 64'(bus.out_valid), 64'd0);

        // Back-pressure: A held, B in skid, C stalled, then release in order.
        bus.out_ready = 1'b0;
        offer(16'h0001, MODE_SEXT);
        step();
        check("bp_a_valid", 64'(bus.out_valid), 64'd1);
        check("bp_a_data",  64'(bus.out_data),  64'h1);
        offer(16'h0002, MODE_ZEXT);
        step();
        check("bp_hold_a_data", 64'(bus.out_data), 64'h1);
        check("bp_skid_ready",  64'(bus.in_ready), 64'd0);
        offer(16'h0003, MODE_SEXT);
        step();
        check("bp_stall_valid", 64'(bus.out_valid), 64'd1);
        check("bp_stall_data",  64'(bus.out_data),  64'h1);
        check("bp_stall_ready", 64'(bus.in_ready),  64'd0);
        bus.out_ready = 1'b1;
        step();
        check("bp_b_data",  64'(bus.out_data), 64'h2);
        check("bp_b_ready", 64'(bus.in_ready), 64'd1);
        step();
        check("bp_c_valid", 64'(bus.out_valid), 64'd1);
        check("bp_c_data",  64'(bus.out_data),  64'h3);
        bus.in_valid = 1'b0;
        step();
        check("bp_drain_valid", 64'(bus.out_valid), 64'd0);

        // Full throughput: eight items, one result per cycle.
        for (int i = 0; i < 8; i++) begin
            offer(16'(16'h0010 + i), MODE_ZEXT);
            check($sformatf("tp%0d_in_ready", i), 64'(bus.in_ready), 64'd1);
            step();
            check($sformatf("tp%0d_valid", i), 64'(bus.out_valid), 64'd1);
            check($sformatf("tp%0d_data", i),  64'(bus.out_data),  64'(32'h10 + i));
        end
        bus.in_valid = 1'b0;
        step();
        check("tp_drain_valid", 64'(bus.out_valid), 64'd0);

        // Flush with output and skid full plus a third item offered.
        bus.out_ready = 1'b0;
        offer(16'h0AAA, MODE_SEXT);
        step();
        offer(16'h0BBB, MODE_SEXT);
        step();
        check("fl_full_valid", 64'(bus.out_valid), 64'd1);
        check("fl_full_ready", 64'(bus.in_ready),  64'd0);
        offer(16'h0CCC, MODE_SEXT);
        flush = 1'b1;
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("fl_out_valid", 64'(bus.out_valid), 64'd0);
        check("fl_in_ready",  64'(bus.in_ready),  64'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("fl_quiet%0d", i), 64'(bus.out_valid), 64'd0);
        end

        // Flush with the unit empty must also discard the offered item.
        offer(16'h0DDD, MODE_SEXT);
        flush = 1'b1;
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("fl_empty_valid", 64'(bus.out_valid), 64'd0);
        offer(16'h00EE, MODE_ZEXT);
        step();
        bus.in_valid = 1'b0;
        check("fl_recover_data", 64'(bus.out_data), 64'hEE);
        step();

        // Reset mid-operation with output and skid full.
        bus.out_ready = 1'b0;
        offer(16'h7FFF, MODE_ZEXT);
        step();
        offer(16'h1111, 3'd6);
        step();
        check("rst_pre_valid", 64'(bus.out_valid), 64'd1);
        check("rst_pre_data",  64'(bus.out_data),  64'h7FFF);
        reset_n = 1'b0;
        flush   = 1'b1;
        step();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data",  64'(bus.out_data),  64'd0);
        check("rst_out_err",   64'(bus.out_err),   64'd0);
        reset_n      = 1'b1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        check("rst_stays_empty", 64'(bus.out_valid), 64'd0);

        // Reset clears a held error flag.
        offer(16'h2222, 3'd7);
        step();
        bus.in_valid = 1'b0;
        check("rst_err_pre", 64'(bus.out_err), 64'd1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("rst_err_post", 64'(bus.out_err), 64'd0);

        // 12-bit immediate, 64-bit result, branch shift of one.
        bus2.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus2.in_valid = 1'b1;
            bus2.in_imm   = vecs64[i].imm;
            bus2.in_mode  = vecs64[i].mode;
            step();
            check($sformatf("w64_%0d_valid", i), 64'(bus2.out_valid), 64'd1);
            check($sformatf("w64_%0d_data", i),  bus2.out_data,       vecs64[i].exp_data);
            check($sformatf("w64_%0d_err", i),   64'(bus2.out_err),   64'(vecs64[i].exp_err));
        end
        bus2.in_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
